vga_sync_monitor: RTL and testbench

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

---
 rtl/vga_sync_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures hsync period and lines per frame of an incoming
// VGA-style bus and reports whether the timing matches the expected values.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   vga_in[7:0]   [0] hsync, [1] vsync, [3:2] r, [5:4] g, [7:6] b
//   clear         synchronous clear of err_cnt
//   locked        high only in the LOCKED state
//   line_len      last measured hsync period (clk cycles, saturates 1023)
//   frame_lines   last measured hsync rises per frame (saturates 255)
//   err_cnt       saturating timing-error count
//   frame_done    one-cycle pulse on each vsync rise in MEASURE/LOCKED
//   frame_crc     CRC-16-CCITT of the last complete frame's pixels
//                 (only when VGA_SYNC_MONITOR_CRC_EN is defined)
//   dbg_state     current FSM state (SEARCH=0, MEASURE=1, LOCKED=2)
//
// Optional feature macro: VGA_SYNC_MONITOR_CRC_EN.
//
// The inputs carry no handshake: vga_in is sampled every cycle, and each
// output is valid in every cycle with no ready/valid qualification.
module vga_sync_monitor #(
  parameter int EXP_LINE_CLKS   = 528,
  parameter int EXP_FRAME_LINES = 133,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_in,
  input  logic        clear,
  output logic        locked,
  output logic [9:0]  line_len,
  output logic [7:0]  frame_lines,
  output logic [7:0]  err_cnt,
  output logic        frame_done,
`ifdef VGA_SYNC_MONITOR_CRC_EN
  output logic [15:0] frame_crc,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] EXP_LEN   = 10'(EXP_LINE_CLKS);
  localparam logic [7:0] EXP_LINES = 8'(EXP_FRAME_LINES);
  localparam logic [7:0] LOCK_N    = 8'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic [7:0]  in_q;
  logic [1:0]  sync2_q;
  logic [9:0]  line_tmr_q, line_tmr_d;
  logic [9:0]  line_len_q, line_len_d;
  logic [7:0]  line_cnt_q, line_cnt_d;
  logic [7:0]  frame_lines_q, frame_lines_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  good_q, good_d;
  logic        bad_q, bad_d;     // current frame had a bad line
  logic        skip_q, skip_d;   // current frame is partial; judge nothing
  logic        fd_q, fd_d;

  logic       h_rise, v_rise, timeout, len_bad, lines_bad, err_inc;
  logic [7:0] good_nxt;

  assign h_rise    = in_q[0] & ~sync2_q[0];
  assign v_rise    = in_q[1] & ~sync2_q[1];
  // The timer holds at 1023, so this fires once per timeout episode.
  assign timeout   = !h_rise && (line_tmr_q == 10'd1022);
  assign len_bad   = h_rise && (line_tmr_q != EXP_LEN);
  assign lines_bad = (line_cnt_q != EXP_LINES);
  assign good_nxt  = (good_q == 8'hFF) ? good_q : good_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    line_tmr_d    = line_tmr_q;
    line_len_d    = line_len_q;
    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;
    good_d        = good_q;
    bad_d         = bad_q;
    skip_d        = skip_q;
    fd_d          = 1'b0;
    err_inc       = 1'b0;

    // Timer is loaded with 1 so that at the next rise it equals the period.
    if (h_rise) begin
      line_len_d = line_tmr_q;
      line_tmr_d = 10'd1;
    end else if (line_tmr_q != 10'd1023) begin
      line_tmr_d = line_tmr_q + 10'd1;
    end

    // A coincident hsync rise is line 1 of the new frame.
    if (v_rise) begin
      frame_lines_d = line_cnt_q;
      line_cnt_d    = h_rise ? 8'd1 : 8'd0;
    end else if (h_rise && line_cnt_q != 8'hFF) begin
      line_cnt_d = line_cnt_q + 8'd1;
    end

    if (timeout) begin
      state_d = SEARCH;
      good_d  = 8'd0;
      bad_d   = 1'b0;
      skip_d  = 1'b0;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        SEARCH: begin
          if (v_rise) begin
            state_d = MEASURE;
            good_d  = 8'd0;
            bad_d   = len_bad;
            skip_d  = 1'b0;
          end
        end
        MEASURE: begin
          if (v_rise) begin
            fd_d   = 1'b1;
            bad_d  = len_bad;
            skip_d = 1'b0;
            if (!skip_q) begin
              if (bad_q || lines_bad) begin
                good_d  = 8'd0;
                err_inc = 1'b1;
              end else begin
                good_d = good_nxt;
                if (good_nxt >= LOCK_N) state_d = LOCKED;
              end
            end
          end else if (len_bad) begin
            bad_d = 1'b1;
          end
        end
        LOCKED: begin
          fd_d = v_rise;
          if (len_bad || (v_rise && lines_bad)) begin
            state_d = MEASURE;
            good_d  = 8'd0;
            err_inc = 1'b1;
            bad_d   = 1'b0;
            // After a bad line the rest of this frame is partial; the error
            // is already counted, so it is neither good nor bad.
            skip_d  = len_bad;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear)                         err_d = 8'd0;
    else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    else                               err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SEARCH;
      in_q          <= 8'd0;
      sync2_q       <= 2'd0;
      line_tmr_q    <= 10'd0;
      line_len_q    <= 10'd0;
      line_cnt_q    <= 8'd0;
      frame_lines_q <= 8'd0;
      err_q         <= 8'd0;
      good_q        <= 8'd0;
      bad_q         <= 1'b0;
      skip_q        <= 1'b0;
      fd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_q          <= vga_in;
      sync2_q       <= in_q[1:0];
      line_tmr_q    <= line_tmr_d;
      line_len_q    <= line_len_d;
      line_cnt_q    <= line_cnt_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      skip_q        <= skip_d;
      fd_q          <= fd_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_cnt     = err_q;
  assign frame_done  = fd_q;
  assign dbg_state   = state_q;

`ifdef VGA_SYNC_MONITOR_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [15:0] frame_crc_q, frame_crc_d;

  // CRC-16-CCITT, MSB first, over the 6 colour bits {b,g,r} (bit 7 first).
  function automatic logic [15:0] crc_step(input logic [15:0] c_in,
                                           input logic [5:0]  d);
    logic [15:0] c;
    c = c_in;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // The vsync-rise cycle's pixels are the first of the new frame. The frame
  // ending at the SEARCH->MEASURE rise is partial and is not published.
  always_comb begin
    crc_d       = crc_step(v_rise ? 16'hFFFF : crc_q, in_q[7:2]);
    frame_crc_d = frame_crc_q;
    if (v_rise && state_q != SEARCH) frame_crc_d = crc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'd0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor with shortened line/frame timing.
module tb_vga_sync_monitor;

  localparam int LEN   = 48;  // clk per line
  localparam int LINES = 8;   // lines per frame
  localparam int HW    = 8;   // hsync high width

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_in = 8'd0;
  logic        clear = 1'b0;
  logic        locked;
  logic [9:0]  line_len;
  logic [7:0]  frame_lines;
  logic [7:0]  err_cnt;
  logic        frame_done;
  logic [1:0]  dbg_state;
`ifdef VGA_SYNC_MONITOR_CRC_EN
  logic [15:0] frame_crc;
  logic [15:0] c1, c2, c3;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  vga_sync_monitor #(
    .EXP_LINE_CLKS(LEN),
    .EXP_FRAME_LINES(LINES),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_in(vga_in),
    .clear(clear),
    .locked(locked),
    .line_len(line_len),
    .frame_lines(frame_lines),
    .err_cnt(err_cnt),
    .frame_done(frame_done),
`ifdef VGA_SYNC_MONITOR_CRC_EN
    .frame_crc(frame_crc),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic drive(input logic h, input logic v, input logic [5:0] pix);
    @(posedge clk);
    #1;
    vga_in = {pix, v, h};
  endtask

  task automatic send_line(input int len, input logic vs, input logic flip, input int start);
    for (int i = start; i < len; i++)
      drive(i < HW, vs, 6'(i) ^ ((flip && i == 20) ? 6'd1 : 6'd0));
  endtask

  task automatic send_frame(input int lines, input logic flip);
    for (int l = 0; l < lines; l++) send_line(LEN, l < 2, flip && l == 3, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_frame_lines", frame_lines, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_state", dbg_state, 0);
`ifdef VGA_SYNC_MONITOR_CRC_EN
    chk("rst_crc", frame_crc, 0);
`endif
    rst = 1'b0;

    // acquire: preamble lines, then three vsync rises
    for (int l = 0; l < 3; l++) send_line(LEN, 1'b0, 1'b0, 0);
    send_frame(LINES, 1'b0);
    chk("acq_fd_first", fd_cnt, 0);
    send_frame(LINES, 1'b0);
    chk("acq_locked_2v", locked, 0);
    send_frame(LINES, 1'b0);
    chk("acq_locked", locked, 1);
    chk("acq_line_len", line_len, LEN);
    chk("acq_frame_lines", frame_lines, LINES);
    chk("acq_err", err_cnt, 0);
    chk("acq_fd_cnt", fd_cnt, 2);

    // stretch line 2 of a locked frame by 2 clk
    send_line(LEN, 1'b1, 1'b0, 0);
    send_line(LEN, 1'b1, 1'b0, 0);
    send_line(LEN + 2, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 6'd0);
    @(posedge clk); @(negedge clk);
    chk("stretch_locked_1clk", locked, 1);
    @(posedge clk); @(negedge clk);
    chk("stretch_locked_2clk", locked, 0);
    chk("stretch_line_len", line_len, LEN + 2);
    chk("stretch_err", err_cnt, 1);
    send_line(LEN, 1'b0, 1'b0, 3);
    for (int l = 4; l < LINES; l++) send_line(LEN, 1'b0, 1'b0, 0);
    send_frame(LINES, 1'b0);
    send_frame(LINES, 1'b0);
    chk("relock_early", locked, 0);
    send_frame(LINES, 1'b0);
    chk("relock", locked, 1);
    chk("relock_err", err_cnt, 1);

    // short frame while locked
    send_frame(LINES - 1, 1'b0);
    send_frame(LINES, 1'b0);
    chk("short_frame_lines", frame_lines, LINES - 1);
    chk("short_err", err_cnt, 2);
    chk("short_locked", locked, 0);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    chk("clear_err", err_cnt, 0);

    // hsync held low past the timer limit
    idle(1100);
    chk("to_state", dbg_state, 0);
    chk("to_err", err_cnt, 1);
    chk("to_locked", locked, 0);
    idle(1100);
    chk("to_err_once", err_cnt, 1);

    // reacquire, capture per-frame CRCs
    for (int l = 0; l < 3; l++) send_line(LEN, 1'b0, 1'b0, 0);
    send_frame(LINES, 1'b0);
    send_frame(LINES, 1'b0);
`ifdef VGA_SYNC_MONITOR_CRC_EN
    c1 = frame_crc;
`endif
    send_frame(LINES, 1'b1);
`ifdef VGA_SYNC_MONITOR_CRC_EN
    c2 = frame_crc;
`endif
    send_frame(LINES, 1'b0);
`ifdef VGA_SYNC_MONITOR_CRC_EN
    c3 = frame_crc;
    chk("crc_equal", c2, c1);
    checks++;
    assert (c3 !== c2) else begin
      errors++;
      $error("FAIL crc_differ: observed %0h expected not %0h", c3, c2);
    end
`endif
    chk("reacq_locked", locked, 1);
    chk("reacq_err", err_cnt, 1);

    // asynchronous reset mid-frame while locked
    for (int l = 0; l < 3; l++) send_line(LEN, l < 2, 1'b0, 0);
    chk("pre_rst_locked", locked, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_line_len", line_len, 0);
    chk("mid_rst_frame_lines", frame_lines, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_fd", frame_done, 0);
`ifdef VGA_SYNC_MONITOR_CRC_EN
    chk("mid_rst_crc", frame_crc, 0);
`endif
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int l = 3; l < LINES; l++) send_line(LEN, 1'b0, 1'b0, 0);
    send_frame(LINES, 1'b0);
    send_frame(LINES, 1'b0);
    chk("post_rst_2v", locked, 0);
    send_frame(LINES, 1'b0);
    chk("post_rst_locked", locked, 1);
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_line_len", line_len, LEN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
